// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: single-outstanding data-memory bus between the bridge (master) and memory (slave).
interface dmem_bridge_if;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    modport master (output o_req, o_we, o_addr, o_wdata, input i_gnt, i_rvalid, i_rdata);
    modport slave (input o_req, o_we, o_addr, o_wdata, output i_gnt, i_rvalid, i_rdata);
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: core load/store port to req/gnt memory bus with posted-write FIFO and read timeout.
module dmem_bridge #(
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read_en,
    input  logic         i_write_en,
    input  logic [31:0]  i_addr,
    input  logic [31:0]  i_wdata,
    output logic [31:0]  o_rdata,
    output logic         o_read_vd,
    output logic         o_stall,
    output logic         o_err,
    dmem_bridge_if.master bus
);
    localparam int AW = $clog2(WBUF_DEPTH);
    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_RESP} state_t;

    state_t        r_state, w_next;
    logic [63:0]   r_mem [WBUF_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic [15:0]   r_tcnt;
    logic [31:0]   r_raddr, r_rdata;
    logic          r_err;
    logic          w_push, w_pop, w_full, w_empty, w_capture, w_timeout;
    logic [63:0]   w_head;

    assign w_full    = r_cnt == (AW+1)'(WBUF_DEPTH);
    assign w_empty   = r_cnt == '0;
    assign w_push    = i_write_en & ~w_full;
    assign w_pop     = (r_state == WR_REQ) & bus.i_gnt;
    assign w_head    = r_mem[r_rp];
    assign o_stall   = (w_full & i_write_en) | (i_read_en & (r_state != RD_RESP));
    assign o_read_vd = r_state == RD_RESP;
    assign o_rdata   = r_rdata;
    assign o_err     = r_err;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    // Writes drain before any read leaves IDLE, preserving store->load ordering.
    always_comb begin
        w_next      = r_state;
        bus.o_req   = 1'b0;
        bus.o_we    = 1'b0;
        bus.o_addr  = '0;
        bus.o_wdata = '0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE:    w_next = !w_empty ? WR_REQ : i_read_en ? RD_REQ : IDLE;
            WR_REQ: begin
                bus.o_req   = 1'b1;
                bus.o_we    = 1'b1;
                bus.o_addr  = w_head[63:32];
                bus.o_wdata = w_head[31:0];
                w_next      = bus.i_gnt ? IDLE : WR_REQ;
            end
            RD_REQ: begin
                bus.o_req  = 1'b1;
                bus.o_addr = r_raddr;
                w_next     = bus.i_gnt ? RD_WAIT : RD_REQ;
            end
            RD_WAIT: begin
                w_capture = bus.i_rvalid;
                w_timeout = !bus.i_rvalid && r_tcnt == TMAX;
                w_next    = (w_capture || w_timeout) ? RD_RESP : RD_WAIT;
            end
            RD_RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= {i_addr, i_wdata};

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_raddr <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wp   <= r_wp + AW'(w_push);
            r_rp   <= r_rp + AW'(w_pop);
            r_cnt  <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_tcnt <= (r_state == RD_WAIT) ? r_tcnt + 16'd1 : 16'd0;
            r_err  <= w_timeout;
            if (r_state == IDLE && w_next == RD_REQ) r_raddr <= i_addr;
            if (w_capture) r_rdata <= bus.i_rdata;
            else if (w_timeout) r_rdata <= 32'hDEADBEEF;
        end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of dmem_bridge loads, posted stores, ordering, timeout and reset.
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_read_en, i_write_en;
    logic [31:0] i_addr, i_wdata;
    logic [31:0] o_rdata;
    logic        o_read_vd, o_stall, o_err;
    int          n_chk = 0;
    int          n_fail = 0;

    dmem_bridge_if bus();

    dmem_bridge #(.WBUF_DEPTH(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .i_read_en(i_read_en), .i_write_en(i_write_en),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_read_vd(o_read_vd),
        .o_stall(o_stall), .o_err(o_err), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        i_read_en = re; i_write_en = we; i_addr = a; i_wdata = wd;
        bus.i_gnt = g; bus.i_rvalid = rv; bus.i_rdata = rd;
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_e;
    logic [31:0] wd_tab [8];
    int          n_st, n_pop;

    initial begin
        rst = 1'b0; i_read_en = 0; i_write_en = 0; i_addr = 0; i_wdata = 0;
        bus.i_gnt = 0; bus.i_rvalid = 0; bus.i_rdata = 0;
        #1;
        chk("rst_req", bus.o_req, 0);
        chk("rst_we", bus.o_we, 0);
        chk("rst_addr", bus.o_addr, 0);
        chk("rst_wdata", bus.o_wdata, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_read_vd", o_read_vd, 0);
        chk("rst_err", o_err, 0);
        i_read_en = 1; #1;
        chk("rst_stall_follows", o_stall, 1);
        i_read_en = 0; #1;
        chk("rst_stall_low", o_stall, 0);
        @(negedge clk); rst = 1'b1;

        // Load to 0x100, grant at once, rvalid three cycles after acceptance
        drive(1, 0, 'h100, 0, 1, 0, 0);
        chk("ld_idle_stall", o_stall, 1);
        chk("ld_idle_req", bus.o_req, 0);
        drive(1, 0, 'h100, 0, 1, 0, 0);
        chk("ld_rdreq_req", bus.o_req, 1);
        chk("ld_rdreq_we", bus.o_we, 0);
        chk("ld_rdreq_addr", bus.o_addr, 'h100);
        chk("ld_rdreq_stall", o_stall, 1);
        drive(1, 0, 'h100, 0, 0, 0, 0);
        chk("ld_wait1_req", bus.o_req, 0);
        chk("ld_wait1_stall", o_stall, 1);
        drive(1, 0, 'h100, 0, 0, 0, 0);
        chk("ld_wait2_vd", o_read_vd, 0);
        drive(1, 0, 'h100, 0, 0, 1, 'hCAFEF00D);
        chk("ld_wait3_stall", o_stall, 1);
        drive(1, 0, 'h100, 0, 0, 0, 0);
        chk("ld_resp_vd", o_read_vd, 1);
        chk("ld_resp_rdata", o_rdata, 'hCAFEF00D);
        chk("ld_resp_stall", o_stall, 0);
        chk("ld_resp_err", o_err, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ld_after_vd", o_read_vd, 0);
        chk("ld_hold_rdata", o_rdata, 'hCAFEF00D);

        // Three stores with no grant: FIFO of two fills, third stalls
        drive(0, 1, 'h10, 'h11111111, 0, 0, 0);
        chk("st1_stall", o_stall, 0);
        drive(0, 1, 'h20, 'h22222222, 0, 0, 0);
        chk("st2_stall", o_stall, 0);
        chk("st2_req", bus.o_req, 0);
        drive(0, 1, 'h30, 'h33333333, 0, 0, 0);
        chk("st3_stall", o_stall, 1);
        chk("st3_req", bus.o_req, 1);
        chk("st3_we", bus.o_we, 1);
        chk("st3_addr", bus.o_addr, 'h10);
        chk("st3_wdata", bus.o_wdata, 'h11111111);
        drive(0, 1, 'h30, 'h33333333, 1, 0, 0);
        chk("st3_gnt_stall", o_stall, 1);
        chk("st3_gnt_addr_stable", bus.o_addr, 'h10);
        drive(0, 1, 'h30, 'h33333333, 0, 0, 0);
        chk("st3_push_stall", o_stall, 0);
        chk("st3_push_req", bus.o_req, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("wr2_addr", bus.o_addr, 'h20);
        chk("wr2_wdata", bus.o_wdata, 'h22222222);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wr2_idle_req", bus.o_req, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("wr3_req", bus.o_req, 1);
        chk("wr3_addr", bus.o_addr, 'h30);
        chk("wr3_wdata", bus.o_wdata, 'h33333333);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wr_drained_req", bus.o_req, 0);

        // Store to 0x40 then load to 0x40: write reaches bus first
        drive(0, 1, 'h40, 'hA5A5A5A5, 1, 0, 0);
        drive(1, 0, 'h40, 0, 1, 0, 0);
        chk("ord_idle_req", bus.o_req, 0);
        chk("ord_idle_stall", o_stall, 1);
        drive(1, 0, 'h40, 0, 1, 0, 0);
        chk("ord_wr_we", bus.o_we, 1);
        chk("ord_wr_addr", bus.o_addr, 'h40);
        chk("ord_wr_wdata", bus.o_wdata, 'hA5A5A5A5);
        drive(1, 0, 'h40, 0, 1, 0, 0);
        chk("ord_gap_req", bus.o_req, 0);
        drive(1, 0, 'h40, 0, 1, 0, 0);
        chk("ord_rd_req", bus.o_req, 1);
        chk("ord_rd_we", bus.o_we, 0);
        chk("ord_rd_addr", bus.o_addr, 'h40);
        drive(1, 0, 'h40, 0, 0, 1, 'h12345678);
        drive(1, 0, 'h40, 0, 0, 0, 0);
        chk("ord_resp_vd", o_read_vd, 1);
        chk("ord_resp_rdata", o_rdata, 'h12345678);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Read timeout with TIMEOUT=4
        drive(1, 0, 'h200, 0, 1, 0, 0);
        drive(1, 0, 'h200, 0, 1, 0, 0);
        chk("to_req", bus.o_req, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 'h200, 0, 0, 0, 0);
            chk($sformatf("to_wait%0d_err", i), o_err, 0);
            chk($sformatf("to_wait%0d_vd", i), o_read_vd, 0);
        end
        drive(1, 0, 'h200, 0, 0, 0, 0);
        chk("to_err", o_err, 1);
        chk("to_vd", o_read_vd, 1);
        chk("to_rdata", o_rdata, 'hDEADBEEF);
        chk("to_stall", o_stall, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("to_err_pulse", o_err, 0);
        chk("to_rdata_hold", o_rdata, 'hDEADBEEF);

        // Reset during RD_WAIT, then a late rvalid must be ignored
        drive(1, 0, 'h300, 0, 1, 0, 0);
        drive(1, 0, 'h300, 0, 1, 0, 0);
        drive(1, 0, 'h300, 0, 0, 0, 0);
        rst = 1'b0; #1;
        chk("rw_rst_rdata", o_rdata, 0);
        chk("rw_rst_req", bus.o_req, 0);
        chk("rw_rst_addr", bus.o_addr, 0);
        chk("rw_rst_vd", o_read_vd, 0);
        chk("rw_rst_stall", o_stall, 1);
        i_read_en = 0; #1;
        chk("rw_rst_stall_low", o_stall, 0);
        @(negedge clk);
        rst = 1'b1; bus.i_rvalid = 1; bus.i_rdata = 'h77777777;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("late_rv_rdata", o_rdata, 0);
        chk("late_rv_vd", o_read_vd, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("late_rv_vd2", o_read_vd, 0);

        // Pending write abandoned by reset
        drive(0, 1, 'h500, 'h55555555, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ab_req_before", bus.o_req, 1);
        rst = 1'b0; #1;
        chk("ab_rst_req", bus.o_req, 0);
        chk("ab_rst_wdata", bus.o_wdata, 0);
        @(negedge clk); rst = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("ab_no_replay", bus.o_req, 0);

        // Eight stores with random grant: bus order equals push order
        for (int i = 0; i < 8; i++) wd_tab[i] = $urandom;
        n_st = 0; n_pop = 0;
        for (int c = 0; c < 300 && (n_st < 8 || n_pop < 8); c++) begin
            @(negedge clk);
            i_write_en = n_st < 8;
            i_addr = 32'h1000 + 32'(n_st * 4);
            i_wdata = wd_tab[n_st % 8];
            bus.i_gnt = 1'($urandom_range(0, 1));
            #1;
            if (bus.o_req && bus.o_we && bus.i_gnt) begin
                exp_e = (q.size() > 0) ? q.pop_front() : 64'hX;
                chk($sformatf("wrap_addr%0d", n_pop), bus.o_addr, exp_e[63:32]);
                chk($sformatf("wrap_wdata%0d", n_pop), bus.o_wdata, exp_e[31:0]);
                n_pop++;
            end
            if (i_write_en && !o_stall) begin
                q.push_back({i_addr, i_wdata});
                n_st++;
            end
        end
        i_write_en = 0; bus.i_gnt = 0;
        chk("wrap_pops", n_pop, 8);
        chk("wrap_pushes", n_st, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, meaning posted-write buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of RD_WAIT cycles before a read is aborted (1..65535).
REQ-003 SHALL have port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_read_en/i_write_en  input  1 each: core load/store request levels.
REQ-006 SHALL have ports i_addr  input  32  core byte address, and i_wdata  input  32  core store data (already lane-merged).
REQ-007 SHALL have ports o_rdata  output  32  load data, and o_read_vd  output  1  load-data-valid pulse to the core.
REQ-008 SHALL have port o_stall  output  1: drives the core external stall.
REQ-009 SHALL have port o_err  output  1: one-cycle pulse on a read timeout.
REQ-010 SHALL have bus ports o_req  1, o_we  1, o_addr  32, o_wdata  32 (outputs), and i_gnt  1, i_rvalid  1, i_rdata  32 (inputs).

Function
REQ-011 SHALL implement the FSM states IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_RESP.
REQ-012 SHALL accept a bus transfer on any cycle with o_req=1 and i_gnt=1; o_req, o_we, o_addr and o_wdata SHALL hold stable from assertion until acceptance.
REQ-013 SHALL push {i_addr,i_wdata} into the write FIFO on each cycle with i_write_en=1 and the FIFO not full; a write is complete to the core on push.
REQ-014 SHALL assert o_stall combinationally when the write FIFO is full and i_write_en=1; a full FIFO SHALL ignore the write, with no same-cycle pop bypass.
REQ-015 SHALL assert o_stall when i_read_en=1 and the FSM is not in RD_RESP.
REQ-016 SHALL move IDLE->WR_REQ when the FIFO is non-empty; in WR_REQ it SHALL drive o_req=1, o_we=1 and the FIFO head.
REQ-017 SHALL, on write acceptance, pop the FIFO and return to IDLE; back-to-back writes therefore cost at least 2 cycles each.
REQ-018 SHALL move IDLE->RD_REQ only when i_read_en=1 and the FIFO is empty; pending writes always drain before a read (ordering).
REQ-019 SHALL, in RD_REQ, drive o_req=1, o_we=0 and o_addr=i_addr captured on entry, then go to RD_WAIT on acceptance.
REQ-020 SHALL ignore i_rvalid outside RD_WAIT; the earliest i_rvalid is the cycle after acceptance.
REQ-021 SHALL, in RD_WAIT, capture i_rdata into o_rdata on i_rvalid=1 and go to RD_RESP.
REQ-022 SHALL count RD_WAIT cycles with a counter; when the count reaches TIMEOUT it SHALL set o_rdata=32'hDEADBEEF, pulse o_err and go to RD_RESP.
REQ-023 SHALL, in RD_RESP, assert o_read_vd for exactly one cycle, then return to IDLE unconditionally.
REQ-024 SHALL let a following load issue no earlier than the cycle after RD_RESP, so one load is never answered twice.
REQ-025 SHALL hold o_rdata until the next capture.
REQ-026 SHALL accept pushes during RD_* states, which are serviced after RD_RESP.
REQ-027 SHALL hold o_req low in IDLE, RD_WAIT and RD_RESP.
REQ-028 SHALL let FIFO pointers wrap modulo WBUF_DEPTH; the FIFO SHALL allow a simultaneous push and pop when not full; the count SHALL never exceed WBUF_DEPTH or go negative.

Reset
REQ-029 SHALL, on rst low, immediately set the FSM to IDLE, empty the FIFO, clear the timeout counter, and drive o_req=0, o_we=0, o_read_vd=0, o_err=0, o_rdata=0, o_addr=0 and o_wdata=0.
REQ-030 SHALL abandon, without replay, any in-flight bus transfer or pending write at reset mid-operation.
REQ-031 SHALL keep o_stall combinational; it follows its inputs even during reset.

Verification
REQ-032 SHALL pass: a load to 0x100, i_gnt=1 immediately, i_rvalid 3 cycles later with 0xCAFEF00D -> o_stall=1 until RD_RESP, and o_read_vd pulses once with o_rdata=0xCAFEF00D.
REQ-033 SHALL pass: 3 consecutive store cycles with i_gnt=0 -> 2 pushes, o_stall=1 on the third cycle, and the third store is accepted only after the first bus acceptance.
REQ-034 SHALL pass: a store to 0x40 immediately followed by a load to 0x40 -> the bus shows the write accepted before the read o_req rises.
REQ-035 SHALL pass: a load accepted with i_rvalid never asserted, TIMEOUT=4 -> after 4 RD_WAIT cycles o_err=1, o_read_vd=1 and o_rdata=0xDEADBEEF in the same cycle.
REQ-036 SHALL pass: rst asserted low during RD_WAIT -> the same-cycle outputs go to reset values, and after release the IDLE state ignores a late i_rvalid.
REQ-037 SHALL pass: 8 wrapped store/drain cycles with random i_gnt -> bus write order and data match push order exactly.
